// File: rtl/minterm_lut_sweeper_if.sv
// Handshake/config bundle for minterm_lut_sweeper: config write, eval lookup and sweep stream.
interface minterm_lut_sweeper_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned W = 1 << N;

    logic         cfg_we;
    logic [W-1:0] cfg_mask;
    logic         cfg_err;
    logic [N-1:0] eval_in;
    logic         eval_f;
    logic         sweep_start;
    logic         sweep_busy;
    logic         sweep_valid;
    logic         sweep_ready;
    logic [N-1:0] sweep_idx;
    logic         sweep_f;
    logic         sweep_done;
    logic [N:0]   minterm_count;

    modport master (
        output cfg_we, cfg_mask, eval_in, sweep_start, sweep_ready,
        input  cfg_err, eval_f, sweep_busy, sweep_valid, sweep_idx, sweep_f, sweep_done,
               minterm_count
    );

    modport slave (
        input  cfg_we, cfg_mask, eval_in, sweep_start, sweep_ready,
        output cfg_err, eval_f, sweep_busy, sweep_valid, sweep_idx, sweep_f, sweep_done,
               minterm_count
    );
endinterface

// File: rtl/minterm_lut_sweeper.sv
// Register-programmable N-input Boolean function held as a 2^N-bit minterm mask, with a
// one-cycle eval path and a sweep engine streaming (index, value) beats plus a popcount.
module minterm_lut_sweeper #(
    parameter int unsigned           N          = 4,
    parameter logic [(1 << N) - 1:0] MASK_RESET = 16'h88B7
) (
    input logic                      clk,
    input logic                      rst_n,
    minterm_lut_sweeper_if.slave     bus
);
    localparam int unsigned W = 1 << N;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] mask_q, mask_d;
    logic [W-1:0] snap_q, snap_d;
    logic [N-1:0] idx_q, idx_d;
    logic [N:0]   acc_q, acc_d;
    logic [N:0]   count_q, count_d;
    logic         eval_f_q;
    logic         cfg_err_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        count_d = count_q;

        if (bus.cfg_we && state_q == StIdle) begin
            mask_d = bus.cfg_mask;
        end

        unique case (state_q)
            StIdle: begin
                // Snapshot takes the post-write mask so cfg_we + sweep_start sweeps the new one.
                if (bus.sweep_start) begin
                    snap_d  = mask_d;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.sweep_ready) begin
                    acc_d = acc_q + {{N{1'b0}}, snap_q[idx_q]};
                    if (idx_q == {N{1'b1}}) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                count_d = acc_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mask_q    <= MASK_RESET;
            snap_q    <= MASK_RESET;
            idx_q     <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            eval_f_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            eval_f_q  <= mask_q[bus.eval_in];
            cfg_err_q <= bus.cfg_we && (state_q != StIdle);
        end
    end

    assign bus.eval_f        = eval_f_q;
    assign bus.cfg_err       = cfg_err_q;
    assign bus.sweep_busy    = (state_q != StIdle);
    assign bus.sweep_valid   = (state_q == StRun);
    assign bus.sweep_idx     = idx_q;
    assign bus.sweep_f       = snap_q[idx_q];
    assign bus.sweep_done    = (state_q == StDone);
    assign bus.minterm_count = count_q;
endmodule

// File: tb/tb_minterm_lut_sweeper.sv
// Directed + randomized bench for minterm_lut_sweeper (N=4 and N=3 instances) against a
// truth-table model kept as a plain mask variable with $countones for the popcount.
module tb_minterm_lut_sweeper;
    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic [15:0] model_mask;
    logic [7:0]  m3;

    minterm_lut_sweeper_if #(.N(4)) sif4 ();
    minterm_lut_sweeper_if #(.N(3)) sif3 ();

    minterm_lut_sweeper #(.N(4), .MASK_RESET(16'h88B7)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif4)
    );

    minterm_lut_sweeper #(.N(3), .MASK_RESET(8'hA5)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic eval4(input logic [3:0] v);
        sif4.eval_in = v;
        @(negedge clk);
        chk("eval_f", 32'(sif4.eval_f), 32'(model_mask[v]));
    endtask

    // Full sweep on the N=4 instance; the consumer model tracks the next expected index.
    task automatic sweep4(input logic [15:0] exp_mask, input bit cfg_start,
                          input logic [15:0] cfg_val, input int stall_at, input int stall_len,
                          input bit rand_rdy, input bit mid_cfg);
        int  exp_idx, busy_cyc, stalls, left, cfg_phase;
        bit  done_seen, rdy;
        exp_idx = 0; busy_cyc = 0; stalls = 0; left = stall_len; cfg_phase = 0;
        done_seen = 1'b0;
        sif4.sweep_start = 1'b1;
        sif4.cfg_we      = cfg_start;
        sif4.cfg_mask    = cfg_val;
        sif4.sweep_ready = 1'b1;
        @(negedge clk);
        sif4.sweep_start = 1'b0;
        sif4.cfg_we      = 1'b0;
        if (cfg_start) begin
            model_mask = cfg_val;
            chk("cfg_err_idle", 32'(sif4.cfg_err), 32'd0);
        end
        for (int g = 0; g < 200 && !done_seen; g++) begin
            if (sif4.sweep_busy) busy_cyc++;
            if (cfg_phase == 1) begin
                chk("cfg_err_pulse", 32'(sif4.cfg_err), 32'd1);
                sif4.cfg_we = 1'b0;
                cfg_phase   = 2;
            end else if (cfg_phase == 2) begin
                chk("cfg_err_clear", 32'(sif4.cfg_err), 32'd0);
                cfg_phase = 3;
            end
            if (sif4.sweep_done) begin
                done_seen = 1'b1;
                chk("done_after_last", exp_idx, 32'd16);
            end else begin
                chk("valid", 32'(sif4.sweep_valid), 32'd1);
                chk("idx", 32'(sif4.sweep_idx), exp_idx);
                chk("f", 32'(sif4.sweep_f), 32'(exp_mask[exp_idx[3:0]]));
                rdy = 1'b1;
                if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
                if (exp_idx == stall_at && left > 0) begin
                    rdy = 1'b0;
                    left--;
                end
                sif4.sweep_ready = rdy;
                if (mid_cfg && exp_idx == 3 && cfg_phase == 0) begin
                    sif4.cfg_we   = 1'b1;
                    sif4.cfg_mask = 16'h0000;
                    cfg_phase     = 1;
                end
                if (rdy) exp_idx++;
                else stalls++;
            end
            @(negedge clk);
        end
        sif4.sweep_ready = 1'b1;
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("busy_cycles", busy_cyc, 32'(17 + stalls));
        chk("done_single", 32'(sif4.sweep_done), 32'd0);
        chk("busy_idle", 32'(sif4.sweep_busy), 32'd0);
        chk("minterm_count", 32'(sif4.minterm_count), 32'($countones(exp_mask)));
    endtask

    initial begin
        int busy3;
        vectors = 0;
        miscompares = 0;
        model_mask = 16'h88B7;
        m3 = 8'hA5;
        {sif4.cfg_we, sif4.sweep_start, sif4.sweep_ready} = 3'b000;
        sif4.cfg_mask = '0;
        sif4.eval_in  = '0;
        {sif3.cfg_we, sif3.sweep_start, sif3.sweep_ready} = 3'b000;
        sif3.cfg_mask = '0;
        sif3.eval_in  = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_eval_f", 32'(sif4.eval_f), 32'd0);
        chk("rst_cfg_err", 32'(sif4.cfg_err), 32'd0);
        chk("rst_busy", 32'(sif4.sweep_busy), 32'd0);
        chk("rst_valid", 32'(sif4.sweep_valid), 32'd0);
        chk("rst_idx", 32'(sif4.sweep_idx), 32'd0);
        chk("rst_f", 32'(sif4.sweep_f), 32'(model_mask[0]));
        chk("rst_done", 32'(sif4.sweep_done), 32'd0);
        chk("rst_count", 32'(sif4.minterm_count), 32'd0);
        chk("rst3_f", 32'(sif3.sweep_f), 32'(m3[0]));
        chk("rst3_count", 32'(sif3.minterm_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) eval4(4'(i));

        // Default sweep, then backpressure at idx 5 for three cycles.
        sweep4(16'h88B7, 1'b0, 16'h0, -1, 0, 1'b0, 1'b0);
        sweep4(16'h88B7, 1'b0, 16'h0, 5, 3, 1'b0, 1'b0);

        // Same-cycle write+start, rejected write mid-run, then sweep of an all-zero mask.
        sweep4(16'hFFFF, 1'b1, 16'hFFFF, -1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i += 5) eval4(4'(i));
        sweep4(16'h0000, 1'b1, 16'h0000, -1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            logic [15:0] rm;
            rm = 16'($urandom);
            sweep4(rm, 1'b1, rm, -1, 0, 1'b1, 1'b0);
            for (int e = 0; e < 6; e++) eval4(4'($urandom_range(0, 15)));
        end

        // Leave a non-reset mask and non-zero count, then reset in the middle of a sweep.
        sweep4(16'h00FF, 1'b1, 16'h00FF, -1, 0, 1'b0, 1'b0);
        sif4.sweep_ready = 1'b1;
        sif4.sweep_start = 1'b1;
        @(negedge clk);
        sif4.sweep_start = 1'b0;
        for (int g = 0; g < 40 && sif4.sweep_idx != 4'd9; g++) @(negedge clk);
        chk("reach_idx9", 32'(sif4.sweep_idx), 32'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(sif4.sweep_busy), 32'd0);
        chk("arst_valid", 32'(sif4.sweep_valid), 32'd0);
        chk("arst_idx", 32'(sif4.sweep_idx), 32'd0);
        chk("arst_done", 32'(sif4.sweep_done), 32'd0);
        chk("arst_count", 32'(sif4.minterm_count), 32'd0);
        chk("arst_eval_f", 32'(sif4.eval_f), 32'd0);
        chk("arst_f", 32'(sif4.sweep_f), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_mask = 16'h88B7;
        sweep4(16'h88B7, 1'b0, 16'h0, -1, 0, 1'b0, 1'b0);
        eval4(4'd3);
        eval4(4'd15);

        // N=3 instance with its own reset mask.
        sif3.sweep_ready = 1'b1;
        sif3.sweep_start = 1'b1;
        @(negedge clk);
        sif3.sweep_start = 1'b0;
        busy3 = 0;
        for (int i = 0; i < 8; i++) begin
            if (sif3.sweep_busy) busy3++;
            chk("n3_valid", 32'(sif3.sweep_valid), 32'd1);
            chk("n3_idx", 32'(sif3.sweep_idx), i);
            chk("n3_f", 32'(sif3.sweep_f), 32'(m3[i]));
            @(negedge clk);
        end
        if (sif3.sweep_busy) busy3++;
        chk("n3_done", 32'(sif3.sweep_done), 32'd1);
        @(negedge clk);
        chk("n3_done_single", 32'(sif3.sweep_done), 32'd0);
        chk("n3_busy_cycles", busy3, 32'd9);
        chk("n3_count", 32'(sif3.minterm_count), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
